// File: rtl/status_reg.sv
// Processor status register: six stored flags, explicit flag instructions,
// ALU flag loads, stack pull/push images and a registered branch decision.
module status_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_v,
  input  logic       upd_c,
  input  logic [2:0] flag_op,
  input  logic       pull_en,
  input  logic [7:0] pull_data,
  input  logic       irq_entry,
  input  logic       push_brk,
  output logic [7:0] push_data,
  input  logic       branch_eval,
  input  logic [2:0] cond,
  output logic       branch_taken,
  output logic [7:0] p,
  output logic       carry,
  output logic       decimal
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_CLC = 3'b001,
    OP_SEC = 3'b010,
    OP_CLI = 3'b011,
    OP_SEI = 3'b100,
    OP_CLD = 3'b101,
    OP_SED = 3'b110,
    OP_CLV = 3'b111
  } flag_op_t;

  typedef enum logic [2:0] {
    BR_PL = 3'b000,
    BR_MI = 3'b001,
    BR_VC = 3'b010,
    BR_VS = 3'b011,
    BR_CC = 3'b100,
    BR_CS = 3'b101,
    BR_NE = 3'b110,
    BR_EQ = 3'b111
  } cond_t;

  logic flag_n, flag_v, flag_d, flag_i, flag_z, flag_c;
  logic next_n, next_v, next_d, next_i, next_z, next_c;
  logic cond_met;

  flag_op_t op;
  cond_t    br;

  // Bits 5 and 4 of a pulled byte have no storage behind them.
  logic unused_pull_bits;
  assign unused_pull_bits = ^pull_data[5:4];

  assign op = flag_op_t'(flag_op);
  assign br = cond_t'(cond);

  // A pull replaces everything; otherwise ALU loads apply first so that an
  // explicit flag instruction, and then interrupt entry, can override them.
  always_comb begin
    next_n = flag_n;
    next_v = flag_v;
    next_d = flag_d;
    next_i = flag_i;
    next_z = flag_z;
    next_c = flag_c;
    if (pull_en) begin
      next_n = pull_data[7];
      next_v = pull_data[6];
      next_d = pull_data[3];
      next_i = pull_data[2];
      next_z = pull_data[1];
      next_c = pull_data[0];
    end else begin
      if (upd_nz) begin
        next_n = alu_n;
        next_z = alu_z;
      end
      if (upd_v) begin
        next_v = alu_v;
      end
      if (upd_c) begin
        next_c = alu_c;
      end
      case (op)
        OP_NOP: ;
        OP_CLC: next_c = 1'b0;
        OP_SEC: next_c = 1'b1;
        OP_CLI: next_i = 1'b0;
        OP_SEI: next_i = 1'b1;
        OP_CLD: next_d = 1'b0;
        OP_SED: next_d = 1'b1;
        OP_CLV: next_v = 1'b0;
      endcase
      if (irq_entry) begin
        next_i = 1'b1;
      end
    end
  end

  // Branch condition is judged on the flags as they stand before this edge.
  always_comb begin
    cond_met = 1'b0;
    case (br)
      BR_PL: cond_met = ~flag_n;
      BR_MI: cond_met = flag_n;
      BR_VC: cond_met = ~flag_v;
      BR_VS: cond_met = flag_v;
      BR_CC: cond_met = ~flag_c;
      BR_CS: cond_met = flag_c;
      BR_NE: cond_met = ~flag_z;
      BR_EQ: cond_met = flag_z;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_n <= 1'b0;
      flag_v <= 1'b0;
      flag_d <= 1'b0;
      flag_i <= 1'b1;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      flag_n <= next_n;
      flag_v <= next_v;
      flag_d <= next_d;
      flag_i <= next_i;
      flag_z <= next_z;
      flag_c <= next_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken <= 1'b0;
    end else if (branch_eval) begin
      branch_taken <= cond_met;
    end
  end

  assign p         = {flag_n, flag_v, 2'b11, flag_d, flag_i, flag_z, flag_c};
  assign push_data = {flag_n, flag_v, 1'b1, push_brk, flag_d, flag_i, flag_z, flag_c};
  assign carry     = flag_c;
  assign decimal   = flag_d;

endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 The block SHALL have the port `clk`: input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, asynchronous, active-high reset.
REQ-003 The block SHALL have the ports `alu_n`, `alu_v`, `alu_z`, `alu_c`: input, 1 bit each, ALU result flags; `alu_z` = 1 means the result was zero.
REQ-004 The block SHALL have the ports `upd_nz`, `upd_v`, `upd_c`: input, 1 bit each, per-flag load enables from the ALU.
REQ-005 The block SHALL have the port `flag_op`: input, 3 bits, explicit flag instruction: 000 NOP, 001 CLC, 010 SEC, 011 CLI, 100 SEI, 101 CLD, 110 SED, 111 CLV.
REQ-006 The block SHALL have the port `pull_en`: input, 1 bit, PLP/RTI load strobe.
REQ-007 The block SHALL have the port `pull_data`: input, 8 bits, byte read from the stack.
REQ-008 The block SHALL have the port `irq_entry`: input, 1 bit, interrupt/BRK entry strobe; it sets I.
REQ-009 The block SHALL have the port `push_brk`: input, 1 bit, value of the B bit in the pushed byte (1 for PHP/BRK, 0 for IRQ/NMI).
REQ-010 The block SHALL have the port `push_data`: output, 8 bits, combinational {N,V,1,push_brk,D,I,Z,C}.
REQ-011 The block SHALL have the port `branch_eval`: input, 1 bit, strobe to evaluate a branch condition.
REQ-012 The block SHALL have the port `cond`: input, 3 bits: 000 BPL, 001 BMI, 010 BVC, 011 BVS, 100 BCC, 101 BCS, 110 BNE, 111 BEQ.
REQ-013 The block SHALL have the port `branch_taken`: output, 1 bit, registered branch decision.
REQ-014 The block SHALL have the port `p`: output, 8 bits, {N,V,1,1,D,I,Z,C}.
REQ-015 The block SHALL have the port `carry`: output, 1 bit, equal to C; this drives the ALU carry-in.
REQ-016 The block SHALL have the port `decimal`: output, 1 bit, equal to D; this drives the ALU BCD enable.

Function
REQ-017 The block SHALL store six flag flops (N, V, D, I, Z, C); bits 5 and 4 of `p` SHALL be constant 1 and SHALL NOT be stored.
REQ-018 The block SHALL resolve per-edge update priority, highest first, as: `rst` > `pull_en` > `irq_entry` (I only) > `flag_op` > ALU enables.
REQ-019 When `pull_en`=1, N, V, D, I, Z, C SHALL load `pull_data` bits 7, 6, 3, 2, 1, 0; bits 5 and 4 SHALL be ignored; all other update sources SHALL be ignored that cycle.
REQ-020 When `irq_entry`=1, I SHALL be set to 1; other flags SHALL still update from `flag_op` and the ALU per REQ-021 to REQ-023.
REQ-021 When `upd_nz`=1, N SHALL take `alu_n` and Z SHALL take `alu_z`.
REQ-022 When `upd_v`=1, V SHALL take `alu_v`; when `upd_c`=1, C SHALL take `alu_c`.
REQ-023 A non-NOP `flag_op` SHALL override a simultaneous ALU update of the same flag (e.g. SEC with `upd_c`=1, `alu_c`=0 gives C=1); flags it does not name SHALL still take their ALU updates.
REQ-024 When `irq_entry`=1 and `flag_op`=CLI occur together, I SHALL end as 1.
REQ-025 Updated flags SHALL appear on `p`, `carry` and `decimal` one cycle after the strobe edge (latency 1); flags with no active source SHALL hold their value.
REQ-026 On `branch_eval`=1, `branch_taken` SHALL register the condition evaluated on flag values before that edge's update; `branch_taken` SHALL hold between strobes.
REQ-027 `push_data` SHALL reflect the current stored flags, with no bypass of same-cycle updates.

Reset
REQ-028 While `rst`=1, asynchronously: N, V, D, Z, C = 0; I = 1; `p` = 8'h34; `branch_taken` = 0.
REQ-029 A reset asserted mid-update SHALL discard that update, and all sources SHALL be ignored until the first edge after `rst` deasserts.

Verification
REQ-030 Reset, then a pull of 8'hFF -> `p` = 8'hFF, `push_data` with `push_brk`=0 = 8'hEF.
REQ-031 SEC with `upd_c`=1, `alu_c`=0 -> C=1; next cycle CLC + `upd_nz` (`alu_n`=1, `alu_z`=1) -> `p` = 8'hB6 starting from the reset state plus N, Z (C=0, I=1).
REQ-032 `pull_en` with `pull_data`=8'h00, simultaneous with SEI and `irq_entry` -> `p` = 8'h30.
REQ-033 Z=1, then `branch_eval` with `cond`=111 in the same cycle as an ALU update clearing Z -> `branch_taken`=1, Z=0 after the edge.
REQ-034 `rst` asserted between edges during a pending SED -> `p` = 8'h34 immediately; D stays 0 after `rst` releases.
